// File: rtl/sram_stream_port.sv
// sram_stream_port: merges write and read request streams onto one single-port SRAM and returns read data through a 3-entry response FIFO.
// Define SRAM_PORT_RR_ARB_EN for a round-robin tie-break; otherwise writes win ties.
module sram_stream_port #(
    parameter int numWord     = 1024,
    parameter int numBit      = 32,
    parameter int numWordAddr = $clog2(numWord)
) (
    input  logic                   CLK,
    input  logic                   RSTB,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [numWordAddr-1:0] wr_addr,
    input  logic [numBit-1:0]      wr_data,
    input  logic                   rd_valid,
    output logic                   rd_ready,
    input  logic [numWordAddr-1:0] rd_addr,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [numBit-1:0]      rsp_data,
    output logic                   CEB,
    output logic                   WEB,
    output logic [numWordAddr-1:0] A,
    output logic [numBit-1:0]      D,
    input  logic [numBit-1:0]      Q
);
    logic [1:0]        rsp_count, wptr, rptr;
    logic              rd_pend, rd_elig, wr_gnt, rd_gnt, push, pop;
    logic [numBit-1:0] mem [3];

    // Credit counts the in-flight read so a push can never hit a full FIFO.
    assign rd_elig = ({1'b0, rsp_count} + {2'b0, rd_pend}) <= 3'd2;

`ifdef SRAM_PORT_RR_ARB_EN
    logic last_wr;

    always_comb begin
        rd_gnt = RSTB && rd_valid && rd_elig && (!wr_valid || last_wr);
        wr_gnt = RSTB && wr_valid && !(rd_valid && rd_elig && last_wr);
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB)
            last_wr <= 1'b1;
        else if (wr_gnt || rd_gnt)
            last_wr <= wr_gnt;
    end
`else
    always_comb begin
        wr_gnt = RSTB && wr_valid;
        rd_gnt = RSTB && rd_valid && rd_elig && !wr_valid;
    end
`endif

    assign wr_ready  = wr_gnt;
    assign rd_ready  = rd_gnt;
    assign CEB       = !(wr_gnt || rd_gnt);
    assign WEB       = !wr_gnt;
    assign A         = wr_gnt ? wr_addr : rd_gnt ? rd_addr : '0;
    assign D         = wr_gnt ? wr_data : '0;
    assign push      = rd_pend;
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_valid = rsp_count != 2'd0;
    assign rsp_data  = mem[rptr];

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            rd_pend   <= 1'b0;
            rsp_count <= 2'd0;
            wptr      <= 2'd0;
            rptr      <= 2'd0;
            for (int i = 0; i < 3; i++) mem[i] <= '0;
        end else begin
            rd_pend   <= rd_gnt;
            rsp_count <= rsp_count + {1'b0, push} - {1'b0, pop};
            if (push) begin
                mem[wptr] <= Q;
                wptr      <= (wptr == 2'd2) ? 2'd0 : wptr + 2'd1;
            end
            if (pop)
                rptr <= (rptr == 2'd2) ? 2'd0 : rptr + 2'd1;
        end
    end
endmodule

// File: doc/sram_stream_port.md
# sram_stream_port

Request front-end for the 1024x32 single-port SRAM macro. It merges a write request stream and a read request stream onto the macro's one access port, tracks its one-cycle read latency, and returns read data on a valid/ready response stream through a 3-entry buffer. It sits directly upstream of the SRAM and drives its CEB/WEB/A/D pins; it also consumes Q.

## Interface
- numWord, 1024, SRAM depth in words
- numBit, 32, data width
- numWordAddr, 10, address width
- CLK  in  1  clock; all state updates on rising edge
- RSTB  in  1  asynchronous, active-low reset
- wr_valid  in  1  write request present
- wr_ready  out  1  write accepted this cycle when high together with wr_valid
- wr_addr  in  numWordAddr  write address
- wr_data  in  numBit  write data
- rd_valid  in  1  read request present
- rd_ready  out  1  read accepted this cycle when high together with rd_valid
- rd_addr  in  numWordAddr  read address
- rsp_valid  out  1  response data available
- rsp_ready  in  1  consumer takes response this cycle
- rsp_data  out  numBit  read data, FIFO head
- CEB  out  1  SRAM chip enable, active-low
- WEB  out  1  SRAM write enable, active-low (1 = read)
- A  out  numWordAddr  SRAM address
- D  out  numBit  SRAM write data
- Q  in  numBit  SRAM read data, valid the cycle after a read edge

## Operation
- At most one SRAM access per cycle. The SRAM samples CEB/WEB/A/D on the same edge that completes the accepting handshake.
- CEB, WEB, A and D are combinational from the current grant:
  - write grant: CEB=0, WEB=0, A=wr_addr, D=wr_data
  - read grant: CEB=0, WEB=1, A=rd_addr, D=0
  - no grant: CEB=1, WEB=1, A=0, D=0
- Read credit: read eligible iff rsp_count + rd_pend ≤ 2.
  - rsp_count is FIFO occupancy (0..3).
  - rd_pend is the 1-bit in-flight flag.
- Arbitration:
  - rd_ready and wr_ready are grants, never both high.
  - A non-eligible read never blocks a write.
  - Tie-break between a valid write and an eligible read is set by Configuration.
- rd_pend is set on a read-accept edge and cleared on the next edge, unless another read is accepted on that edge.
- On the edge where rd_pend=1, Q is pushed into the response FIFO.
- FIFO: 3 entries, in-order. Push and pop may occur on the same edge; occupancy is then unchanged. Pop happens when rsp_valid && rsp_ready.
- Credit rule guarantees no push into a full FIFO. Overflow is unreachable; the bench asserts on it.
- Read-after-write to the same address in consecutive cycles returns the new data, because the SRAM orders accesses.

## Timing
- Read latency: read accepted at edge k, Q valid after k, push at k+1, rsp_valid high after k+1 (2 cycles).
- Throughput: one read per cycle sustained while rsp_ready=1. Writes also run one per cycle.
- With rsp_ready=0 from empty, exactly 3 reads are accepted, then rd_ready=0 until a pop.
- Reset (RSTB low, asynchronous):
  - rsp_count=0, rd_pend=0, arbitration pointer=write-last, FIFO contents=0
  - outputs: wr_ready=0, rd_ready=0, rsp_valid=0, rsp_data=0, CEB=1, WEB=1, A=0, D=0
  - Grants are gated by RSTB, so no SRAM access occurs while reset is low.
- Reset mid-operation: an in-flight read and all buffered responses are discarded. The first grant is possible in the first cycle with RSTB high.

## Configuration
- SRAM_PORT_RR_ARB_EN defined: round-robin tie-break.
  - A 1-bit last-grant register, updated on every grant, gives the tie to the stream not granted last.
  - Reset value: last=write, so the first tie goes to read.
- Not defined: fixed write priority.
  - A valid write always wins a tie; reads starve under continuous writes.
  - No last-grant register is built.

## Test plan
- Reset, write 0xDEADBEEF to addr 5, then read addr 5 with rsp_ready=1 -> CEB=0/WEB=0/A=5 on the write cycle; rsp_data=0xDEADBEEF with rsp_valid 2 cycles after the read accept.
- Write addrs 0..3 with data 0x10..0x13, then 4 back-to-back reads of 0..3 with rsp_ready=1 -> rd_ready held high, responses 0x10,0x11,0x12,0x13 on 4 consecutive cycles.
- rsp_ready=0, rd_valid held high -> exactly 3 accepts, then rd_ready=0. Raise rsp_ready -> data drains in order, and rd_ready rises one cycle after the first pop.
- wr_valid and rd_valid both high for 4 cycles -> without the macro: 4 writes then reads. With SRAM_PORT_RR_ARB_EN: order R,W,R,W.
- Write 0xA5A5A5A5 to addr 9, then read addr 9 on the next cycle -> response 0xA5A5A5A5.
- Read accepted, RSTB pulsed low on the following cycle -> rsp_valid stays 0, CEB=1 during reset. A fresh read after release returns correct data with 2-cycle latency.
